// File: rtl/shift_unit_iter_if.sv
// Bus bundle for the iterative shift unit.
//
// Handshake: the requester raises start together with op, amt_sel, amt_in*
// and data_in; the unit takes them on the rising edge only while it is idle
// or in its done cycle (start is ignored while busy is high). The result is
// valid on data_out during the single cycle that done is high and is held
// until the next accepted request.
//
// Signals:
//   start, op, amt_sel, amt_in0/1/3, data_in : requester -> unit
//   data_out, amt_used, busy, done           : unit -> requester
//   state_dbg                                : unit -> observer, FSM state
interface shift_unit_iter_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
);
  logic             start;
  logic [2:0]       op;
  logic [1:0]       amt_sel;
  logic [SHW-1:0]   amt_in0;
  logic [SHW-1:0]   amt_in1;
  logic [SHW-1:0]   amt_in3;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic [SHW-1:0]   amt_used;
  logic             busy;
  logic             done;
  logic [1:0]       state_dbg;

  modport master (
    output start, op, amt_sel, amt_in0, amt_in1, amt_in3, data_in,
    input  data_out, amt_used, busy, done, state_dbg
  );

  modport slave (
    input  start, op, amt_sel, amt_in0, amt_in1, amt_in3, data_in,
    output data_out, amt_used, busy, done, state_dbg
  );
endinterface

// File: rtl/shift_unit_iter.sv
// Multi-cycle shift/rotate unit.
//
// Latches an operand, an operation and a selected shift amount on start,
// then shifts the working register by up to STEP bits per clock until the
// amount is consumed. Supports SLL, SRL, SRA, ROL and ROR; op codes 000,
// 110 and 111 pass the operand through unchanged.
//
// Ports:
//   clk   : clock, all state changes on the rising edge
//   reset : synchronous, active-low
//   bus   : shift_unit_iter_if.slave (request, result, busy/done, state_dbg)
module shift_unit_iter #(
  parameter int WIDTH     = 32,
  parameter int SHW       = 5,
  parameter int CONST_AMT = 16,
  parameter int STEP      = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  shift_unit_iter_if.slave     bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [2:0] OP_SLL = 3'b001;
  localparam logic [2:0] OP_SRL = 3'b010;
  localparam logic [2:0] OP_SRA = 3'b011;
  localparam logic [2:0] OP_ROL = 3'b100;
  localparam logic [2:0] OP_ROR = 3'b101;

  localparam logic [SHW-1:0] CONST_AMT_W = SHW'(CONST_AMT);
  // One bit wider than the amount so STEP == WIDTH is representable.
  localparam logic [SHW:0]   STEP_W      = (SHW+1)'(STEP);

  state_e           state_q,    state_d;
  logic [WIDTH-1:0] data_q,     data_d;
  logic [2:0]       op_q,       op_d;
  logic [SHW-1:0]   amt_used_q, amt_used_d;
  logic [SHW-1:0]   rem_q,      rem_d;
  logic             busy_q,     busy_d;
  logic             done_q,     done_d;

  logic [SHW-1:0]   sel_amt;
  logic [SHW-1:0]   step_amt;
  logic [SHW-1:0]   rem_next;
  logic             start_is_shift;

  // Shift d by s (s <= STEP) according to op. Rotates use a doubled copy so
  // the bits leaving one end reappear at the other.
  function automatic logic [WIDTH-1:0] shift_by(input logic [2:0]       f_op,
                                                input logic [WIDTH-1:0] d,
                                                input logic [SHW-1:0]   s);
    logic [2*WIDTH-1:0] dbl;
    dbl      = {d, d};
    shift_by = d;
    case (f_op)
      OP_SLL: shift_by = d << s;
      OP_SRL: shift_by = d >> s;
      OP_SRA: shift_by = $signed(d) >>> s;
      OP_ROL: begin
        dbl      = dbl << s;
        shift_by = dbl[2*WIDTH-1:WIDTH];
      end
      OP_ROR: begin
        dbl      = dbl >> s;
        shift_by = dbl[WIDTH-1:0];
      end
      default: shift_by = d;
    endcase
  endfunction

  always_comb begin
    sel_amt = bus.amt_in0;
    case (bus.amt_sel)
      2'd0:    sel_amt = bus.amt_in0;
      2'd1:    sel_amt = bus.amt_in1;
      2'd2:    sel_amt = CONST_AMT_W;
      default: sel_amt = bus.amt_in3;
    endcase
  end

  // Codes 1..5 move bits; everything else behaves as pass-through.
  assign start_is_shift = (bus.op != 3'b000) && (bus.op <= OP_ROR);

  // s = min(STEP, rem). When STEP exceeds every legal amount the STEP_W
  // branch is never taken, so its truncation is harmless.
  assign step_amt = ({1'b0, rem_q} < STEP_W) ? rem_q : STEP_W[SHW-1:0];
  assign rem_next = rem_q - step_amt;

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    op_d       = op_q;
    amt_used_d = amt_used_q;
    rem_d      = rem_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          data_d     = bus.data_in;
          op_d       = bus.op;
          amt_used_d = sel_amt;
          rem_d      = sel_amt;
          if ((sel_amt != '0) && start_is_shift) begin
            state_d = ST_SHIFT;
            busy_d  = 1'b1;
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        data_d = shift_by(op_q, data_q, step_amt);
        rem_d  = rem_next;
        if (rem_next == '0) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          busy_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      data_q     <= '0;
      op_q       <= '0;
      amt_used_q <= '0;
      rem_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      op_q       <= op_d;
      amt_used_q <= amt_used_d;
      rem_q      <= rem_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.data_out  = data_q;
  assign bus.amt_used  = amt_used_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_shift_unit_iter.sv
// Directed bench for shift_unit_iter. Two units are instantiated, one with
// STEP=1 (dut1) and one with STEP=4 (dut4). Each issued request pushes its
// hand-computed result, amount and busy-cycle count into that unit's queue;
// a monitor per unit pops and compares whenever done is seen.
module tb_shift_unit_iter;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  amt;
    logic [7:0]  k;
  } exp_t;

  logic clk;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  exp_t exp_q1[$];
  exp_t exp_q4[$];
  int   busy_cnt1 = 0;
  int   busy_cnt4 = 0;

  shift_unit_iter_if #(.WIDTH(32), .SHW(5)) if1 ();
  shift_unit_iter_if #(.WIDTH(32), .SHW(5)) if4 ();

  shift_unit_iter #(.WIDTH(32), .SHW(5), .CONST_AMT(16), .STEP(1)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (if1.slave)
  );

  shift_unit_iter #(.WIDTH(32), .SHW(5), .CONST_AMT(16), .STEP(4)) u_dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (if4.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- monitors / scoreboard ----------------
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      busy_cnt1 = 0;
    end else begin
      if (if1.busy) busy_cnt1++;
      if (if1.done) begin
        if (exp_q1.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL dut1_unexpected_done: got done=1 expected no result");
        end else begin
          e = exp_q1.pop_front();
          chk("dut1_data", if1.data_out, e.data);
          chk("dut1_amt_used", 32'(if1.amt_used), 32'(e.amt));
          chk("dut1_busy_cycles", 32'(busy_cnt1), 32'(e.k));
        end
        busy_cnt1 = 0;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      busy_cnt4 = 0;
    end else begin
      if (if4.busy) busy_cnt4++;
      if (if4.done) begin
        if (exp_q4.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL dut4_unexpected_done: got done=1 expected no result");
        end else begin
          e = exp_q4.pop_front();
          chk("dut4_data", if4.data_out, e.data);
          chk("dut4_amt_used", 32'(if4.amt_used), 32'(e.amt));
          chk("dut4_busy_cycles", 32'(busy_cnt4), 32'(e.k));
        end
        busy_cnt4 = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input int which, input logic st, input logic [2:0] op,
                         input logic [1:0] sel, input logic [4:0] a0,
                         input logic [4:0] a1, input logic [4:0] a3,
                         input logic [31:0] data);
    if (which == 1) begin
      if1.start = st; if1.op = op; if1.amt_sel = sel;
      if1.amt_in0 = a0; if1.amt_in1 = a1; if1.amt_in3 = a3; if1.data_in = data;
    end else begin
      if4.start = st; if4.op = op; if4.amt_sel = sel;
      if4.amt_in0 = a0; if4.amt_in1 = a1; if4.amt_in3 = a3; if4.data_in = data;
    end
  endtask

  // Called at a falling edge; start is high across exactly one rising edge.
  task automatic issue(input int which, input logic [2:0] op, input logic [1:0] sel,
                       input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a3,
                       input logic [31:0] data, input logic [31:0] exp_data,
                       input logic [4:0] exp_amt, input logic [7:0] exp_k);
    exp_t e;
    e.data = exp_data;
    e.amt  = exp_amt;
    e.k    = exp_k;
    if (which == 1) exp_q1.push_back(e);
    else            exp_q4.push_back(e);
    set_req(which, 1'b1, op, sel, a0, a1, a3, data);
    @(negedge clk);
    if (which == 1) if1.start = 1'b0;
    else            if4.start = 1'b0;
  endtask

  task automatic wait_drain(input int which);
    int left;
    for (int i = 0; i < 200; i++) begin
      left = (which == 1) ? exp_q1.size() : exp_q4.size();
      if (left == 0) break;
      @(negedge clk);
    end
    left = (which == 1) ? exp_q1.size() : exp_q4.size();
    if (left != 0) begin
      checks++;
      failures++;
      $display("FAIL dut%0d_timeout: got %0d pending results expected 0", which, left);
      if (which == 1) exp_q1.delete();
      else            exp_q4.delete();
    end
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit got_done;
    reset = 1'b0;
    set_req(1, 1'b0, 3'b000, 2'd0, 5'd0, 5'd0, 5'd0, 32'h0);
    set_req(4, 1'b0, 3'b000, 2'd0, 5'd0, 5'd0, 5'd0, 32'h0);
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_dut1_data", if1.data_out, 32'h0);
    chk("rst_dut1_amt", 32'(if1.amt_used), 32'h0);
    chk("rst_dut1_busy", 32'(if1.busy), 32'h0);
    chk("rst_dut1_done", 32'(if1.done), 32'h0);
    chk("rst_dut1_state", 32'(if1.state_dbg), 32'h0);
    chk("rst_dut4_data", if4.data_out, 32'h0);
    chk("rst_dut4_busy", 32'(if4.busy), 32'h0);
    chk("rst_dut4_done", 32'(if4.done), 32'h0);
    reset = 1'b1;
    @(negedge clk);

    // STEP=1: SLL by constant 16
    issue(1, 3'b001, 2'd2, 5'd0, 5'd0, 5'd0, 32'h0000ABCD, 32'hABCD0000, 5'd16, 8'd16);
    wait_drain(1);
    // STEP=1: SRA / SRL by amt_in1=4
    issue(1, 3'b011, 2'd1, 5'd0, 5'd4, 5'd0, 32'h800000F0, 32'hF800000F, 5'd4, 8'd4);
    wait_drain(1);
    issue(1, 3'b010, 2'd1, 5'd0, 5'd4, 5'd0, 32'h800000F0, 32'h0800000F, 5'd4, 8'd4);
    wait_drain(1);
    // STEP=1: zero amount and reserved op pass through with no busy cycles
    issue(1, 3'b001, 2'd0, 5'd0, 5'd9, 5'd9, 32'hDEADBEEF, 32'hDEADBEEF, 5'd0, 8'd0);
    wait_drain(1);
    issue(1, 3'b110, 2'd2, 5'd3, 5'd3, 5'd3, 32'hDEADBEEF, 32'hDEADBEEF, 5'd16, 8'd0);
    wait_drain(1);
    // STEP=1: ROR by 1 wraps the LSB to the MSB
    issue(1, 3'b101, 2'd3, 5'd0, 5'd0, 5'd1, 32'h00000001, 32'h80000000, 5'd1, 8'd1);
    wait_drain(1);

    // STEP=4: ROR by 8, ROL by 5 (4 then 1), SLL 16, SRA 31
    issue(4, 3'b101, 2'd3, 5'd0, 5'd0, 5'd8, 32'h12345678, 32'h78123456, 5'd8, 8'd2);
    wait_drain(4);
    issue(4, 3'b100, 2'd0, 5'd5, 5'd0, 5'd0, 32'h80000001, 32'h00000030, 5'd5, 8'd2);
    wait_drain(4);
    issue(4, 3'b001, 2'd2, 5'd0, 5'd0, 5'd0, 32'h0000ABCD, 32'hABCD0000, 5'd16, 8'd4);
    wait_drain(4);
    issue(4, 3'b011, 2'd1, 5'd0, 5'd31, 5'd0, 32'h80000000, 32'hFFFFFFFF, 5'd31, 8'd8);
    wait_drain(4);
    issue(4, 3'b111, 2'd0, 5'd7, 5'd0, 5'd0, 32'hCAFEF00D, 32'hCAFEF00D, 5'd7, 8'd0);
    wait_drain(4);

    // Start pulse during SHIFT is ignored; then back-to-back in the done cycle
    issue(1, 3'b001, 2'd2, 5'd0, 5'd0, 5'd0, 32'h0000ABCD, 32'hABCD0000, 5'd16, 8'd16);
    repeat (2) @(negedge clk);
    set_req(1, 1'b1, 3'b010, 2'd0, 5'd1, 5'd1, 5'd1, 32'hFFFFFFFF);
    @(negedge clk);
    if1.start = 1'b0;
    got_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (if1.done) begin
        got_done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got_done) begin
      checks++;
      failures++;
      $display("FAIL dut1_b2b_wait: got no done expected done within 40 cycles");
    end
    issue(1, 3'b010, 2'd0, 5'd3, 5'd0, 5'd0, 32'h00000080, 32'h00000010, 5'd3, 8'd3);
    wait_drain(1);

    // Reset in the middle of a 16-step shift drops the operation
    issue(1, 3'b001, 2'd2, 5'd0, 5'd0, 5'd0, 32'h00001234, 32'h12340000, 5'd16, 8'd16);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_q1.delete();
    @(negedge clk);
    chk("midrst_data", if1.data_out, 32'h0);
    chk("midrst_amt", 32'(if1.amt_used), 32'h0);
    chk("midrst_busy", 32'(if1.busy), 32'h0);
    chk("midrst_done", 32'(if1.done), 32'h0);
    chk("midrst_state", 32'(if1.state_dbg), 32'h0);
    reset = 1'b1;
    @(negedge clk);
    issue(1, 3'b100, 2'd3, 5'd0, 5'd0, 5'd4, 32'hF0000001, 32'h0000001F, 5'd4, 8'd4);
    wait_drain(1);

    repeat (3) @(negedge clk);
    chk("dut1_queue_empty", 32'(exp_q1.size()), 32'h0);
    chk("dut4_queue_empty", 32'(exp_q4.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
